// File: rtl/clk_div_bank.sv
// Fully synchronous multi-channel clock divider bank with run-time ratio updates.
// New ratios take effect only at period boundaries, so clk_out never glitches.
module clk_div_bank #(
  parameter  int NUM_CH    = 4,
  parameter  int DIV_W     = 8,
  parameter  int DIV_RESET = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] and_mask,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              and_out
);

  localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);
  localparam logic [DIV_W-1:0] DIV_RST_L = DIV_W'(DIV_RESET);
  localparam logic [DIV_W:0]   ONE_W     = (DIV_W+1)'(1);

  logic [NUM_CH-1:0] apply;
  logic              pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic              cfg_xfer;

  // A ratio of 1 runs as 2; the result is one bit wider so H never overflows.
  function automatic logic [DIV_W:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == DIV_W'(1)) ? (DIV_W+1)'(2) : {1'b0, d};
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d, div_now;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [DIV_W:0]   d_cur, d_now, half;
    logic             hit, wrap;

    assign d_cur = eff_div(div_q);
    // >= rather than == so a ratio shrunk while paused still wraps cleanly
    assign wrap  = (div_q != '0) && ({1'b0, cnt_q} >= (d_cur - ONE_W));
    assign hit   = pend_valid_q && (pend_ch_q == CH_W'(i));
    assign apply[i] = hit && ((div_q == '0) || !en || sync || wrap);
    assign div_d = apply[i] ? pend_div_q : div_q;
    // sync restarts the period, so it already runs on a freshly applied ratio
    assign div_now = sync ? div_d : div_q;
    assign d_now   = eff_div(div_now);
    assign half    = (d_now + ONE_W) >> 1;

    always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      if (div_now == '0) begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end else if (sync) begin
        cnt_d     = en ? DIV_W'(1) : '0;
        clk_out_d = en;
        tick_d    = en;
      end else if (en) begin
        clk_out_d = ({1'b0, cnt_q} < half);
        tick_d    = (cnt_q == '0);
        cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q     <= '0;
        div_q     <= DIV_RST_L;
        clk_out_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_q     <= div_d;
        clk_out_q <= clk_out_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[i] = clk_out_q;
    assign tick[i]    = tick_q;
  end

  // An apply on this edge frees the slot in time to accept a new request.
  assign cfg_ready = !pend_valid_q || (|apply);
  assign cfg_xfer  = cfg_valid && cfg_ready;

  always_comb begin
    pend_valid_d = pend_valid_q && !(|apply);
    pend_ch_d    = pend_ch_q;
    pend_div_d   = pend_div_q;
    if (cfg_xfer && ({1'b0, cfg_ch} < NUM_CH_L)) begin
      pend_valid_d = 1'b1;
      pend_ch_d    = cfg_ch;
      pend_div_d   = cfg_div;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_div_q   <= pend_div_d;
    end
  end

  assign and_out = (|and_mask) && (&(clk_out | ~and_mask));

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel, fully synchronous clock-divider bank that replaces ripple-clocked divider chains.
- All state runs on the single `clk`. Each channel produces a divided square wave (`clk_out`) and a one-cycle `tick` strobe. Both are intended for use as clock enables or slow-clock outputs.
- Each channel's divide ratio is programmable at run time through a valid/ready handshake, with glitch-free retiming at period boundaries.
- A global `sync` input phase-aligns all channels. A masked AND combiner replaces the old fixed two-channel AND output.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- DIV_W, 8, width of each divide ratio; maximum ratio is 2^DIV_W-1.
- DIV_RESET, 2, divide ratio loaded into every channel at reset; must be at least 2.
- CH_W (localparam), max(1,clog2(NUM_CH)), channel-select width.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is sampled on `clk`.
- en  in  1  global run enable.
- sync  in  1  one-cycle phase-align strobe.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration slot free.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  new divide ratio D.
- and_mask  in  NUM_CH  channels included in `and_out`.
- clk_out  out  NUM_CH  divided square waves, one bit per channel.
- tick  out  NUM_CH  one-cycle pulse on each channel's period start.
- and_out  out  1  AND of the masked `clk_out` bits.

Behaviour:
- Reset (`reset`=0):
  - all counters `cnt` = 0;
  - `div_r` = DIV_RESET;
  - `clk_out` = 0, `tick` = 0, `and_out` = 0;
  - `cfg_ready` = 1; pending configuration slot cleared.
  - Reset mid-operation aborts any pending configuration.
- Per channel i, D = `div_r[i]` and H = (D+1)>>1, computed at DIV_W+1 bits.
  - D=0: channel stopped. `cnt`=0, `clk_out`=0, `tick`=0.
  - D=1: treated as D=2.
- Rising edge with `en`=1 and D≥2 (outputs are registered):
  - `clk_out` <= (`cnt` < H);
  - `tick` <= (`cnt` == 0);
  - `cnt` <= (`cnt` == D-1) ? 0 : `cnt`+1.
  - First enabled edge after reset gives `clk_out`=1 and `tick`=1.
  - Resulting waveform: period D cycles, high for H cycles. Odd D is high one cycle longer than low.
- `en`=0: `cnt` and `clk_out` hold; `tick` <= 0. Phase resumes unchanged when `en` returns to 1.
- Configuration handshake:
  - Transfer occurs on an edge with `cfg_valid`=1 and `cfg_ready`=1. `cfg_ch` and `cfg_div` are captured into a single pending slot, and `cfg_ready` <= 0.
  - The pending ratio is written to `div_r[cfg_ch]` on the first edge where that channel wraps (`cnt`==D-1 with `en`=1). The new ratio governs the following period.
  - The pending ratio is applied on the next edge instead if the channel is stopped (D=0), `en`=0, or `sync`=1. This also covers restarting a stopped channel.
  - `cfg_ready` returns to 1 on the edge that applies the ratio.
  - A request with `cfg_ch` ≥ NUM_CH is accepted and discarded; `cfg_ready` stays 1.
  - No truncated or stretched period ever appears on `clk_out`.
- `sync`=1:
  - With `en`=1: every channel with D≥2 behaves as if `cnt`==0 on this edge (`clk_out`<=1, `tick`<=1, `cnt`<=1). Any pending configuration is applied first.
  - With `en`=0: all `cnt` <= 0, `tick` <= 0, `clk_out` <= 0.
  - `sync` takes priority over a wrap on the same edge.
- `and_out`: combinational AND of `clk_out[i]` for every i with `and_mask[i]`=1. It is 0 when `and_mask` = 0. Driven only from registers.
- Simultaneous transfer and apply on the same edge: the apply completes first, so `cfg_ready` is 1 in that cycle and the new request is accepted.

Test Plan:
- Reset low → release with `en`=1 and defaults → each `clk_out` reads 1,0,1,0… from the first edge; `tick` pulses every 2nd cycle; all outputs read 0 during reset.
- Write ch1 D=5 at mid-period → `cfg_ready` stays 0 until ch1 wraps; the old period completes intact; then `clk_out[1]` is high 3 / low 2 with `tick[1]` every 5 cycles.
- Write ch2 D=0 → `clk_out[2]` is held 0 after the wrap. Then write D=1 → ch2 applies on the next edge and runs at period 2.
- ch0 D=3 and ch1 D=4 at unaligned phases, pulse `sync`, `and_mask`=0b0011 → `tick[0]` and `tick[1]` assert in the same cycle; `and_out` is high for exactly 2 cycles after `sync`, then 0.
- Drop `en` for 7 cycles mid high-phase → `clk_out` holds and `tick` = 0; on resume the remaining phase count continues exactly.
- Assert `reset` asynchronously between clock edges → outputs go to 0 immediately without waiting for `clk`; `div_r` reverts to 2; the pending slot clears and `cfg_ready` = 1.
